rf_wport_arbiter: RTL
=====================

// Module: rf_wport_arbiter
// PURPOSE
//  Shares the register file's single write port between the pipeline writeback
//  stage (WB) and the multi-cycle mul/div unit (MDU). Fixed priority to WB, with
//  a starvation counter that forces an MDU grant after MAX_WAIT lost cycles.
//  Keeps a scoreboard of registers with an MDU result outstanding, for the
//  hazard unit. Drives the register file's write port from a register stage.
// PARAMETERS
//  DATA_W    32  write data width
//  ADDR_W    5   register address width (2**ADDR_W scoreboard bits)
//  MAX_WAIT  4   cycles MDU may lose arbitration before forced grant; legal >=1
// PORTS
//  clk_i        in   1       clock; all state changes on rising edge
//  rst_i        in   1       reset, asynchronous, active-high
//  wb_valid_i   in   1       WB write request
//  wb_addr_i    in   ADDR_W  WB destination register
//  wb_data_i    in   DATA_W  WB write data
//  wb_ready_o   out  1       WB request accepted this cycle
//  mdu_valid_i  in   1       MDU write request
//  mdu_addr_i   in   ADDR_W  MDU destination register
//  mdu_data_i   in   DATA_W  MDU result
//  mdu_ready_o  out  1       MDU request accepted this cycle
//  issue_i      in   1       MDU op issued; marks issue_addr_i pending
//  issue_addr_i in   ADDR_W  destination of issued MDU op
//  rs_addr_i    in   ADDR_W  hazard query address A
//  rt_addr_i    in   ADDR_W  hazard query address B
//  rs_busy_o    out  1       register rs_addr_i has MDU write outstanding
//  rt_busy_o    out  1       register rt_addr_i has MDU write outstanding
//  rf_we_o      out  1       register file write enable (registered)
//  rf_addr_o    out  ADDR_W  register file write address (registered)
//  rf_data_o    out  DATA_W  register file write data (registered)
//  mdu_prio_o   out  1       FSM in MDU_PRI (status)
// BEHAVIOUR
//  - Handshake: transfer = valid & ready in the same cycle. Requesters hold
//    valid/addr/data stable until ready. Ready signals are combinational.
//  - FSM states WB_PRI (reset state), MDU_PRI.
//    WB_PRI: wb_ready_o=1; mdu_ready_o=!wb_valid_i. Each cycle mdu_valid_i=1
//    without an MDU transfer increments wait_cnt (saturating at MAX_WAIT). Move
//    to MDU_PRI when the count reaches MAX_WAIT.
//    MDU_PRI: mdu_ready_o=1; wb_ready_o=!mdu_valid_i. Return to WB_PRI after the
//    MDU transfer. Also return if mdu_valid_i=0. wait_cnt clears on any MDU
//    transfer.
//  - Latency: a transfer in cycle N gives rf_we_o=1, rf_addr_o=addr and
//    rf_data_o=data in cycle N+1. rf_we_o is one cycle per transfer.
//    rf_addr_o/rf_data_o hold their last value when rf_we_o=0.
//  - Address 0: the transfer completes (ready given). rf_we_o stays 0.
//  - Scoreboard busy[2**ADDR_W]:
//    - issue_i sets busy[issue_addr_i], except address 0.
//    - A committed MDU write clears busy[rf_addr_o] on the edge ending cycle N+1,
//      so busy reads 0 from N+2, when the RF holds the new value.
//    - Set and clear of the same bit on one edge: set wins.
//    - busy[0] is always 0.
//  - rs_busy_o=busy[rs_addr_i], rt_busy_o=busy[rt_addr_i]. Pure read of state,
//    no same-cycle bypass of issue_i.
//  - WB writes never touch the scoreboard.
//  - Reset: rf_we_o, rf_addr_o, rf_data_o, mdu_prio_o, all busy bits and
//    wait_cnt go to 0; state goes to WB_PRI, immediately on rst_i rise.
//    A write accepted just before reset is dropped. Ready outputs follow the
//    WB_PRI equations during reset.
// TESTING
//  1 Assert rst_i mid-cycle -> rf_we_o=0, rs/rt_busy_o=0, mdu_prio_o=0 at
//    once, without waiting for a clock edge.
//  2 WB only: wb_valid_i=1, addr=5, data=32'h1234 in cycle N -> wb_ready_o=1;
//    rf_we_o=1, rf_addr_o=5, rf_data_o=32'h1234 in N+1; rf_we_o=0 in N+2.
//  3 WB and MDU both valid continuously, MAX_WAIT=4 -> WB granted 4 cycles.
//    Then mdu_prio_o=1, wb_ready_o=0 and the MDU is granted in cycle 5.
//    WB is granted again in cycle 6.
//  4 issue_i with addr 9; rs_addr_i=9 -> rs_busy_o=1 from next cycle. MDU
//    transfer to 9 in cycle N -> rs_busy_o=1 in N+1, 0 in N+2. Same-edge
//    issue and clear of 9 -> stays 1.
//  5 WB write to addr 0 with data 32'hFFFF -> wb_ready_o=1, rf_we_o stays 0.
//    issue_i to addr 0 -> rs_busy_o=0 with rs_addr_i=0.
//  6 rst_i pulse during forced MDU grant -> state WB_PRI, busy bits 0,
//    wait_cnt 0. A fresh WB write after reset lands with 1-cycle latency.

Source files
------------

// File: rtl/rf_wport_arbiter.sv
// Register file write-port arbiter: WB has priority, MDU is guaranteed a grant after
// MAX_WAIT lost cycles; tracks outstanding MDU destinations for the hazard unit.
module rf_wport_arbiter #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wb_valid_i,
  input  logic [ADDR_W-1:0] wb_addr_i,
  input  logic [DATA_W-1:0] wb_data_i,
  output logic              wb_ready_o,
  input  logic              mdu_valid_i,
  input  logic [ADDR_W-1:0] mdu_addr_i,
  input  logic [DATA_W-1:0] mdu_data_i,
  output logic              mdu_ready_o,
  input  logic              issue_i,
  input  logic [ADDR_W-1:0] issue_addr_i,
  input  logic [ADDR_W-1:0] rs_addr_i,
  input  logic [ADDR_W-1:0] rt_addr_i,
  output logic              rs_busy_o,
  output logic              rt_busy_o,
  output logic              rf_we_o,
  output logic [ADDR_W-1:0] rf_addr_o,
  output logic [DATA_W-1:0] rf_data_o,
  output logic              mdu_prio_o
);

  localparam int NREG  = 1 << ADDR_W;
  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] WAIT_LIM = CNT_W'(MAX_WAIT);

  typedef enum logic {
    WB_PRI  = 1'b0,
    MDU_PRI = 1'b1
  } state_t;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  wait_cnt_reg, wait_cnt_next;
  logic              wb_xfer, mdu_xfer;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rf_we_reg, mdu_we_reg;
  logic [ADDR_W-1:0] rf_addr_reg;
  logic [DATA_W-1:0] rf_data_reg;
  logic [NREG-1:0]   busy_reg, busy_next;

  always_comb begin
    wb_ready_o    = 1'b1;
    mdu_ready_o   = !wb_valid_i;
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;

    case (state_reg)
      WB_PRI: begin
        wb_ready_o  = 1'b1;
        mdu_ready_o = !wb_valid_i;
      end
      MDU_PRI: begin
        mdu_ready_o = 1'b1;
        wb_ready_o  = !mdu_valid_i;
      end
      default: ;
    endcase

    wb_xfer  = wb_valid_i && wb_ready_o;
    mdu_xfer = mdu_valid_i && mdu_ready_o;

    if (mdu_xfer) begin
      wait_cnt_next = '0;
    end else if (mdu_valid_i && (wait_cnt_reg != WAIT_LIM)) begin
      wait_cnt_next = wait_cnt_reg + CNT_W'(1);
    end

    case (state_reg)
      WB_PRI:  if (mdu_valid_i && !mdu_xfer && (wait_cnt_next == WAIT_LIM)) state_next = MDU_PRI;
      MDU_PRI: if (mdu_xfer || !mdu_valid_i) state_next = WB_PRI;
      default: state_next = WB_PRI;
    endcase

    // At most one transfer per cycle, so a plain mux picks the winner.
    wr_addr = wb_xfer ? wb_addr_i : mdu_addr_i;
    wr_data = wb_xfer ? wb_data_i : mdu_data_i;
    wr_en   = (wb_xfer || mdu_xfer) && (wr_addr != '0);
  end

  // Per-register scoreboard update; a new issue beats a same-edge retire.
  assign busy_next[0] = 1'b0;
  generate
    for (genvar gi = 1; gi < NREG; gi++) begin : g_busy
      assign busy_next[gi] = (issue_i && (issue_addr_i == ADDR_W'(gi))) ||
                             (busy_reg[gi] && !(mdu_we_reg && (rf_addr_reg == ADDR_W'(gi))));
    end
  endgenerate

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg    <= WB_PRI;
      wait_cnt_reg <= '0;
      rf_we_reg    <= 1'b0;
      mdu_we_reg   <= 1'b0;
      rf_addr_reg  <= '0;
      rf_data_reg  <= '0;
      busy_reg     <= '0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      rf_we_reg    <= wr_en;
      mdu_we_reg   <= mdu_xfer && (mdu_addr_i != '0);
      busy_reg     <= busy_next;
      if (wr_en) begin
        rf_addr_reg <= wr_addr;
        rf_data_reg <= wr_data;
      end
    end
  end

  assign rf_we_o    = rf_we_reg;
  assign rf_addr_o  = rf_addr_reg;
  assign rf_data_o  = rf_data_reg;
  assign mdu_prio_o = (state_reg == MDU_PRI);
  assign rs_busy_o  = busy_reg[rs_addr_i];
  assign rt_busy_o  = busy_reg[rt_addr_i];

endmodule
